// File: rtl/alu_pkg.sv
// alu_mc shared definitions: opcodes, FSM states, sign-fix helper.
// Imported by the engine and the top-level ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_DIVU  = 4'b1111;

    // Widest value the sign fix handles: a 2*WIDTH product, so WIDTH <= 64.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic [MAX_W-1:0] sm_fix(
        input logic             neg,
        input logic [MAX_W-1:0] x
    );
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc.
// master drives operands and out_ready; slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             zf;
    logic             ovf;
    logic             dz;
    logic             err;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, lo, hi, zf, ovf, dz, err
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, lo, hi, zf, ovf, dz, err
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring step per cycle
// on operand magnitudes; the signed result is presented combinationally.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               div_q, div_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_lo_q, neg_lo_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     r_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] fix_p;
    logic [WIDTH-1:0]   fix_h, fix_l;

    // op[0] set means unsigned, so sign bits are ignored
    assign sa = ~op[0] & a[WIDTH-1];
    assign sb = ~op[0] & b[WIDTH-1];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;

    assign addend = p_q[0] ? m_q : '0;
    assign acc    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    assign r_sh = p_q[2*WIDTH-1:WIDTH-1];
    assign ge   = r_sh >= {1'b0, m_q};
    assign rem  = ge ? WIDTH'(r_sh - {1'b0, m_q}) : r_sh[WIDTH-1:0];

    assign last = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign busy = busy_q;

    always_comb begin
        p_d      = p_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        div_d    = div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            div_d  = op[1];
            if (op[1]) begin
                p_d      = {{WIDTH{1'b0}}, ma};
                m_d      = mb;
                neg_lo_d = sa ^ sb;
                neg_hi_d = sa;
            end else begin
                p_d      = {{WIDTH{1'b0}}, mb};
                m_d      = ma;
                neg_lo_d = sa ^ sb;
                neg_hi_d = sa ^ sb;
            end
        end else if (busy_q) begin
            if (div_q) begin
                p_d = {rem, p_q[WIDTH-2:0], ge};
            end else begin
                p_d = {acc, p_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            div_q    <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
        end else begin
            p_q      <= p_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            div_q    <= div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
        end
    end

    assign fix_p = (2*WIDTH)'(sm_fix(neg_lo_q, MAX_W'(p_q)));
    assign fix_h = WIDTH'(sm_fix(neg_hi_q, MAX_W'(p_q[2*WIDTH-1:WIDTH])));
    assign fix_l = WIDTH'(sm_fix(neg_lo_q, MAX_W'(p_q[WIDTH-1:0])));

    assign hi = div_q ? fix_h : fix_p[2*WIDTH-1:WIDTH];
    assign lo = div_q ? fix_l : fix_p[WIDTH-1:0];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative MUL/DIV,
// valid/ready on both sides, registered results held until taken.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave io
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             err_q, err_d;

    logic             accept;
    logic             start;
    logic             b_zero;
    logic [WIDTH-1:0] sum, dif;
    logic             slt_bit, sltu_bit;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_ovf, sc_dz, sc_err;
    logic             eng_busy, eng_last;
    logic [WIDTH-1:0] eng_hi, eng_lo;

    assign io.in_ready  = (state_q == S_IDLE) ||
                          (state_q == S_DONE && io.out_ready);
    assign io.out_valid = (state_q == S_DONE);
    assign accept       = io.in_valid && io.in_ready;
    assign b_zero       = (io.b == '0);
    // Divide by zero is answered directly, never iterated
    assign start        = accept && (io.alu_op[3:2] == 2'b11) &&
                          !(io.alu_op[1] && b_zero);

    assign sum = io.a + io.b;
    assign dif = io.a - io.b;
    assign slt_bit  = 1'(({io.a[WIDTH-1], io.a} -
                          {io.b[WIDTH-1], io.b}) >> WIDTH);
    assign sltu_bit = 1'(({1'b0, io.a} - {1'b0, io.b}) >> WIDTH);

    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        sc_err = 1'b0;
        unique case (io.alu_op)
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = (io.a[WIDTH-1] == io.b[WIDTH-1]) &&
                         (sum[WIDTH-1] != io.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo  = dif;
                sc_ovf = (io.a[WIDTH-1] != io.b[WIDTH-1]) &&
                         (dif[WIDTH-1] != io.a[WIDTH-1]);
            end
            OP_AND:  sc_lo = io.a & io.b;
            OP_OR:   sc_lo = io.a | io.b;
            OP_XOR:  sc_lo = io.a ^ io.b;
            OP_NOR:  sc_lo = ~(io.a | io.b);
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, sltu_bit};
            OP_MULT, OP_MULTU: sc_lo = '0;
            OP_DIV, OP_DIVU: begin
                sc_lo = '1;
                sc_hi = io.a;
                sc_dz = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (start) begin
                        state_d = S_ITER;
                    end else begin
                        state_d = S_DONE;
                        lo_d    = sc_lo;
                        hi_d    = sc_hi;
                        ovf_d   = sc_ovf;
                        dz_d    = sc_dz;
                        err_d   = sc_err;
                    end
                end else if (state_q == S_DONE && io.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (eng_last || !eng_busy) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                lo_d    = eng_lo;
                hi_d    = eng_hi;
                ovf_d   = 1'b0;
                dz_d    = 1'b0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            err_q   <= err_d;
        end
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (io.alu_op[1:0]),
        .a     (io.a),
        .b     (io.b),
        .busy  (eng_busy),
        .last  (eng_last),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    assign io.lo  = lo_q;
    assign io.hi  = hi_q;
    assign io.zf  = (lo_q == '0);
    assign io.ovf = ovf_q;
    assign io.dz  = dz_q;
    assign io.err = err_q;

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the next generation of the datapath ALU.
- Keeps the single-cycle integer ops (ADD, SUB, AND, OR, XOR, NOR, SLT) and adds SLTU, signed overflow detection, and iterative MULT/MULTU/DIV/DIVU producing HI/LO.
- Operands arrive over a valid/ready handshake; results leave over one.
- Sits between the register-read stage and writeback; the pipeline stalls on `in_ready` low.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width, ≥4, even.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands/opcode valid
- `in_ready`  out  1  block can accept
- `alu_op`  in  4  opcode
- `a`, `b`  in  WIDTH  operands (`b` = divisor/multiplier)
- `out_valid`  out  1  result valid, held until taken
- `out_ready`  in  1  consumer takes result
- `lo`  out  WIDTH  result / product low / quotient
- `hi`  out  WIDTH  product high / remainder; 0 for single-cycle ops
- `zf`  out  1  `lo` == 0
- `ovf`  out  1  signed overflow (ADD/SUB only)
- `dz`  out  1  divide by zero
- `err`  out  1  reserved opcode

## Operation
Opcodes:
- 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR
- 1010 SLT (signed), 1011 SLTU
- 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU
- 0001, 0011, 1000, 1001 reserved: `lo`=`hi`=0, `err`=1, single-cycle.

Arithmetic and width rules:
- All arithmetic is mod 2^WIDTH.
- `ovf` = operand signs equal (after SUB's inversion of `b`) and result sign differs; 0 for all other ops.
- SLT/SLTU: `lo` = 1 or 0; compare uses the full WIDTH+1-bit difference, so SLT is correct on overflow.
- MULT/MULTU: {`hi`,`lo`} = 2·WIDTH-bit product.
- Multiply algorithm: shift-add on magnitudes; sign fix in the FIX state.
- DIV/DIVU: restoring division on magnitudes.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/−1 gives `lo`=MIN, `hi`=0, no flag.
- `b`==0 on DIV/DIVU: `dz`=1, `lo`=all ones, `hi`=`a`, single-cycle path (no iteration).
- `zf` is computed from the final registered `lo`.

State machine: IDLE, ITER, FIX, DONE.
- IDLE --accept single-cycle op--> DONE
- IDLE --accept MUL/DIV (b≠0 for div)--> ITER
- ITER: step counter 0..WIDTH−1 → FIX after the last step.
- FIX → DONE
- DONE --`out_ready`--> IDLE, or, if a new accept happens in the same cycle, the next state for that op.

Handshake:
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- Accept = `in_valid` & `in_ready`; operands and opcode are captured on that edge.
- `out_valid` = (state==DONE).
- `lo`/`hi`/flags are stable while `out_valid` & !`out_ready`.

## Timing
- Accept in cycle c → single-cycle ops: `out_valid` high in cycle c+1.
- MUL/DIV: ITER cycles c+1..c+WIDTH, FIX in c+WIDTH+1, `out_valid` in c+WIDTH+2.
- Back-to-back single-cycle ops with `out_ready` tied high give 1 result per cycle.
- `in_ready` is low throughout ITER/FIX; `in_valid` during that time is ignored, not queued.
- `rst` at any time, including mid-ITER: next cycle state=IDLE, `out_valid`=0, `in_ready`=1.
  - `lo`=`hi`=0; `zf`=1 (follows `lo`==0); `ovf`=`dz`=`err`=0; counter=0.
  - The in-flight operation is discarded.
- Operand changes after accept have no effect.

## Structure
- Package `alu_pkg`: opcode localparams, state enum, helper function for the signed-magnitude fix.
- Sub-module `alu_muldiv`: iterative engine (WIDTH param, start/op/a/b in, busy, {hi,lo} out), used for ITER plus FIX.
- Top `alu_mc`: decode, single-cycle datapath, FSM, output registers.

## Test plan
- ADD 0x7FFFFFFF+1 (WIDTH=32) → `lo`=0x80000000, `ovf`=1, `zf`=0, `out_valid` 1 cycle after accept.
- SUB 5−5 then SLT −1<1 and SLTU 0xFFFFFFFF<1, back-to-back with `out_ready`=1 → `zf`=1; `lo`=1; `lo`=0, on consecutive cycles.
- MULT −3×7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `out_valid` at c+34; `in_ready`=0 during ITER.
- DIV −7/2 → `lo`=−3, `hi`=−1. DIVU 7/0 → `dz`=1, `lo`=0xFFFFFFFF, `hi`=7 after 1 cycle. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- Hold `out_ready`=0 for 5 cycles in DONE → outputs stable. Assert `rst` mid-ITER → IDLE next cycle, `out_valid`=0.
- Reserved opcode 1000 → `err`=1, `lo`=0, `zf`=1. Rerun MULTU 0xF×0xF with WIDTH=8 → `hi`=0x00, `lo`=0xE1.
